// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the execute-stage divider controller.
package cpu_defs;

    localparam int DATA_W      = 32;
    localparam int REM_MSB     = 63;
    localparam int REM_LSB     = 32;
    localparam int QUO_MSB     = 31;
    localparam int QUO_LSB     = 0;
    localparam int DIV_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DONE   = 2'd2,
        ST_CANCEL = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU to the multi-cycle divider, stalls EX while it runs and
// writes HI/LO on completion; aborts on flush or watchdog expiry.
module div_issue_ctrl
    import cpu_defs::*;
#(
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid_i,
    input  logic              op_signed_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic              div_start_o,
    output logic              div_signed_o,
    output logic [DATA_W-1:0] div_dividend_o,
    output logic [DATA_W-1:0] div_divider_o,
    output logic              div_cancel_o,
    input  logic [63:0]       div_result_i,
    input  logic              div_success_i,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              timeout_o
);

    localparam int WD_W = $clog2(TIMEOUT);

    div_state_e        r_state;
    div_state_e        w_state_nxt;
    logic [WD_W-1:0]   r_wd;
    logic [1:0]        r_drain;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_signed;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              w_issue;
    logic              w_wd_expired;

    assign w_issue      = op_valid_i & ~flush_i;
    assign w_wd_expired = (r_wd == WD_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt  = r_state;
        stall_req_o  = 1'b0;
        div_start_o  = 1'b0;
        div_cancel_o = 1'b0;
        hilo_we_o    = 1'b0;
        timeout_o    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall_req_o = w_issue;
                if (w_issue) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_req_o = 1'b1;
                div_start_o = 1'b1;
                if (flush_i) begin
                    w_state_nxt = ST_CANCEL;
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_CANCEL;
                    timeout_o   = 1'b1;
                end else if (div_success_i) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Start drops here, which releases the divider from its end state.
                hilo_we_o   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_CANCEL: begin
                div_cancel_o = 1'b1;
                // A zero-divisor run can still raise success after cancel; wait it out.
                if (r_drain == 2'd2 && !div_success_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wd     <= '0;
            r_drain  <= 2'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_a      <= op_a_i;
                        r_b      <= op_b_i;
                        r_signed <= op_signed_i;
                        r_wd     <= '0;
                    end
                end
                ST_WAIT: begin
                    r_wd    <= r_wd + WD_W'(1);
                    // Preloaded so the first CANCEL cycle counts as drain cycle one.
                    r_drain <= 2'd1;
                    if (w_state_nxt == ST_DONE) begin
                        r_hi <= div_result_i[REM_MSB:REM_LSB];
                        r_lo <= div_result_i[QUO_MSB:QUO_LSB];
                    end
                end
                ST_CANCEL: begin
                    if (r_drain != 2'd2) begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_signed_o   = r_signed;
    assign div_dividend_o = r_a;
    assign div_divider_o  = r_b;
    assign hi_o           = r_hi;
    assign lo_o           = r_lo;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural multi-cycle divider and a
// never-finishing stub for the watchdog path.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid_i = 1'b0;
    logic        op_signed_i = 1'b0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_req_o, div_start_o, div_signed_o, div_cancel_o;
    logic [31:0] div_dividend_o, div_divider_o, hi_o, lo_o;
    logic        hilo_we_o, timeout_o;

    logic        to_valid = 1'b0;
    logic        to_flush = 1'b0;
    logic [31:0] to_a = 32'd100;
    logic [31:0] to_b = 32'd7;
    logic [63:0] to_result = '0;
    logic        to_success = 1'b0;
    logic        to_stall, to_start, to_signed, to_cancel, to_we, to_timeout;
    logic [31:0] to_dividend, to_divider, to_hi, to_lo;

    typedef enum logic [1:0] {DV_FREE, DV_ZERO, DV_ON, DV_END} dv_e;
    dv_e         dv_st;
    int          dv_cnt;
    logic        dv_succ;
    logic [63:0] dv_res;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[6];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int wr_count = 0;
    int last_wr_cyc = 0;
    int to_wr_count = 0;
    int to_pulses = 0;
    int to_pulse_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_issue_ctrl u_dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_signed_i(op_signed_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_dividend_o(div_dividend_o), .div_divider_o(div_divider_o),
        .div_cancel_o(div_cancel_o), .div_result_i(dv_res), .div_success_i(dv_succ),
        .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .timeout_o(timeout_o)
    );

    div_issue_ctrl #(.TIMEOUT(20)) u_dut_to (
        .clk(clk), .rst(rst), .op_valid_i(to_valid), .op_signed_i(1'b0),
        .op_a_i(to_a), .op_b_i(to_b), .flush_i(to_flush), .stall_req_o(to_stall),
        .div_start_o(to_start), .div_signed_o(to_signed),
        .div_dividend_o(to_dividend), .div_divider_o(to_divider),
        .div_cancel_o(to_cancel), .div_result_i(to_result), .div_success_i(to_success),
        .hilo_we_o(to_we), .hi_o(to_hi), .lo_o(to_lo), .timeout_o(to_timeout)
    );

    function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, b);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = a; sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    // Divider: free -> on (33 cycles) -> end; zero divisor takes a short path.
    always @(posedge clk) begin
        if (rst) begin
            dv_st <= DV_FREE; dv_cnt <= 0; dv_succ <= 1'b0; dv_res <= '0;
        end else begin
            case (dv_st)
                DV_FREE: if (div_start_o && !div_cancel_o) begin
                    dv_st  <= (div_divider_o == 32'd0) ? DV_ZERO : DV_ON;
                    dv_cnt <= 0;
                end
                DV_ZERO: dv_st <= DV_END;
                DV_ON: begin
                    if (div_cancel_o || !div_start_o) dv_st <= DV_FREE;
                    else if (dv_cnt == 32) dv_st <= DV_END;
                    else dv_cnt <= dv_cnt + 1;
                end
                DV_END: begin
                    if (!dv_succ) begin
                        dv_succ <= 1'b1;
                        dv_res  <= div_model(div_signed_o, div_dividend_o, div_divider_o);
                    end else if (!div_start_o) begin
                        dv_succ <= 1'b0;
                        dv_st   <= DV_FREE;
                    end
                end
                default: dv_st <= DV_FREE;
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        #1;
        if (hilo_we_o) begin
            wr_count++;
            last_wr_cyc = cyc;
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("hi", {32'd0, hi_o}, {32'd0, mon_e.hi});
                check("lo", {32'd0, lo_o}, {32'd0, mon_e.lo});
            end
        end
        if (to_we) to_wr_count++;
        if (to_timeout) begin
            to_pulses++;
            to_pulse_cyc = cyc;
        end
    end

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] ehi, input logic [31:0] elo);
        int   t0, w0, bad_stall, bad_start;
        exp_t e;
        @(negedge clk);
        op_valid_i = 1'b1; op_signed_i = sgn; op_a_i = a; op_b_i = b; flush_i = 1'b0;
        e.hi = ehi; e.lo = elo;
        sb_q.push_back(e);
        t0 = cyc; w0 = wr_count; bad_stall = -1; bad_start = -1;
        for (int n = 0; n <= lat; n++) begin
            if (n > 0) @(negedge clk);
            #2;
            if (stall_req_o !== (n < lat) && bad_stall < 0) bad_stall = n;
            if (div_start_o !== (n >= 1 && n < lat) && bad_start < 0) bad_start = n;
        end
        check("stall_window", 64'(bad_stall), 64'(-1));
        check("start_window", 64'(bad_start), 64'(-1));
        check("write_count", 64'(wr_count - w0), 64'd1);
        check("write_latency", 64'(last_wr_cyc - t0), 64'(lat));
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: bench did not finish within its time bound");
        $fatal(1, "bench time bound exceeded");
    end

    initial begin
        int w0, t0, p0;
        vecs[0] = '{1'b0, 32'd100,        32'd7,          37, 32'd2,        32'd14};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          37, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  37, 32'd1,        32'hFFFF_FFFD};
        vecs[3] = '{1'b1, 32'd5,          32'd0,          5,  32'd0,        32'd0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd16,         37, 32'd15,       32'h0FFF_FFFF};
        vecs[5] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  37, 32'hFFFF_FFFE, 32'd14};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_ctrl", 64'({stall_req_o, div_start_o, div_cancel_o, hilo_we_o, timeout_o}), 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_operands", {div_dividend_o, div_divider_o}, 64'd0);
        check("rst_signed", 64'(div_signed_o), 64'd0);

        // Back-to-back issues: each new op is presented in the cycle after DONE.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hi, vecs[i].lo);
        end

        // Flush in WAIT at t10, then an immediate new op.
        @(negedge clk);
        op_valid_i = 1'b1; op_signed_i = 1'b0; op_a_i = 32'd100; op_b_i = 32'd7;
        w0 = wr_count;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 10) flush_i = 1'b1;
            if (n == 11) begin flush_i = 1'b0; op_valid_i = 1'b0; end
            #2;
            if (n == 10) check("flush_no_cancel_yet", 64'(div_cancel_o), 64'd0);
            if (n == 11) check("flush_cancel_t11", 64'(div_cancel_o), 64'd1);
            if (n == 12) check("flush_cancel_t12", 64'(div_cancel_o), 64'd1);
        end
        check("flush_no_write", 64'(wr_count - w0), 64'd0);
        run_op(1'b0, 32'd9, 32'd3, 37, 32'd0, 32'd3);

        // Flush at t2 of a zero-divisor op: cancel must outlast the late success.
        @(negedge clk);
        op_valid_i = 1'b1; op_signed_i = 1'b1; op_a_i = 32'd5; op_b_i = 32'd0;
        w0 = wr_count;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 2) flush_i = 1'b1;
            if (n == 3) begin flush_i = 1'b0; op_valid_i = 1'b0; end
            #2;
            if (n == 4) check("zflush_succ_seen", 64'(dv_succ), 64'd1);
            if (n >= 3) check("zflush_cancel", 64'(div_cancel_o), 64'd1);
        end
        check("zflush_no_write", 64'(wr_count - w0), 64'd0);
        run_op(1'b0, 32'd8, 32'd2, 37, 32'd0, 32'd4);

        // Reset in the middle of a division.
        @(negedge clk);
        op_valid_i = 1'b1; op_signed_i = 1'b0; op_a_i = 32'd100; op_b_i = 32'd7;
        w0 = wr_count;
        for (int n = 1; n <= 5; n++) @(negedge clk);
        rst = 1'b1; op_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("midrst_ctrl", 64'({stall_req_o, div_start_o, div_cancel_o}), 64'd0);
        check("midrst_operands", {div_dividend_o, div_divider_o}, 64'd0);
        repeat (40) @(negedge clk);
        check("midrst_no_write", 64'(wr_count - w0), 64'd0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 37, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clk);
        op_valid_i = 1'b0;

        // Watchdog on the TIMEOUT=20 instance with a divider that never finishes.
        @(negedge clk);
        to_valid = 1'b1;
        t0 = cyc; p0 = to_pulses; w0 = to_wr_count;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (n == 21) to_valid = 1'b0;
            #2;
            if (n == 20) check("wd_stall_t20", 64'(to_stall), 64'd1);
            if (n == 21) check("wd_stall_drop", 64'(to_stall), 64'd0);
            if (n == 21) check("wd_cancel", 64'(to_cancel), 64'd1);
            if (n == 23) check("wd_idle", 64'(to_cancel), 64'd0);
        end
        check("wd_pulse_count", 64'(to_pulses - p0), 64'd1);
        check("wd_pulse_cycle", 64'(to_pulse_cyc - t0), 64'd20);
        check("wd_no_write", 64'(to_wr_count - w0), 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
